rotate_sequencer: RTL and testbench
===================================

ROTATE_SEQUENCER -- requirements
Module: rotate_sequencer

Interface
REQ-001 SHALL have parameter N, default 8, data width in bits; power of two, N >= 2.
REQ-002 SHALL have derived localparam W = $clog2(N), width of the rotate amount.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port up_valid  input  1  request present.
REQ-006 SHALL have port up_ready  output  1  request accepted this cycle when high with up_valid.
REQ-007 SHALL have port up_data  input  N  word to rotate.
REQ-008 SHALL have port up_amount  input  W  rotate distance, 0..N-1.
REQ-009 SHALL have port up_dir  input  1  0 = circular left, 1 = circular right.
REQ-010 SHALL have port down_valid  output  1  result present.
REQ-011 SHALL have port down_ready  input  1  consumer takes result when high with down_valid.
REQ-012 SHALL have port down_data  output  N  rotated word.
REQ-013 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement FSM with states IDLE, BUSY, DONE.
REQ-015 SHALL assert up_ready only in IDLE; down_valid only in DONE.
REQ-016 IDLE: on up_valid && up_ready, SHALL load data register with up_data, count with up_amount, dir register with up_dir; next state BUSY if up_amount != 0, else DONE.
REQ-017 BUSY: each cycle SHALL rotate data register by exactly one bit in registered direction and decrement count; when count == 1 at the edge, next state DONE.
REQ-018 Latency SHALL be up_amount + 1 cycles from accept edge to first cycle of down_valid.
REQ-019 Left rotation SHALL map bit i to bit (i+1) mod N; right rotation SHALL map ABCDEFGH -> FGHABCDE for N = 8, amount 3.
REQ-020 DONE: down_data SHALL equal data register and stay stable while down_valid && !down_ready.
REQ-021 DONE: on down_ready, next state IDLE; new request SHALL NOT be accepted in same cycle (up_ready low in DONE).
REQ-022 Inputs up_data/up_amount/up_dir SHALL be ignored outside accept cycle; changes during BUSY/DONE SHALL not affect result.
REQ-023 count arithmetic SHALL be W bits unsigned with no wrap below 0 reachable.
REQ-024 down_data SHALL be driven from register only (no combinational path from up_* to down_*).

Reset
REQ-025 On rst_n low, asynchronously: state IDLE, data register 0, count 0, dir 0.
REQ-026 Outputs during and after reset: up_ready 1, down_valid 0, down_data 0, busy 0.
REQ-027 Reset asserted mid-BUSY or mid-DONE SHALL discard operation; no down_valid after release until new accept.

Structure
REQ-028 Package rotate_pkg SHALL hold state enum (IDLE, BUSY, DONE) and direction constants DIR_LEFT = 0, DIR_RIGHT = 1.
REQ-029 One combinational sub-module rotate_step SHALL produce one-bit left or right circular rotation of N-bit word, selected by dir; instantiated once.

Verification
REQ-030 N=8, up_data=8'b10110001, amount 3, dir left -> down_data 8'b10001101, down_valid 4 cycles after accept.
REQ-031 N=8, up_data=8'b10110001, amount 3, dir right -> down_data 8'b00110110, 4 cycles after accept.
REQ-032 amount 0, up_data=8'hA5 -> down_data 8'hA5, down_valid 1 cycle after accept, busy high exactly that cycle pair.
REQ-033 up_data=8'h01, amount 7, dir right -> down_data 8'h02 after 8 cycles; up_ready low throughout.
REQ-034 down_ready held low 5 cycles in DONE while up_data toggles -> down_data/down_valid stable, up_ready 0; result consumed on first down_ready high, IDLE next cycle.
REQ-035 rst_n pulsed low during BUSY (amount 5, cycle 2) -> outputs immediately at reset values, no down_valid after release; next request 8'hF0 left 4 -> 8'h0F.

Source files
------------

// File: rtl/rotate_pkg.sv
// Shared types and constants for the rotate sequencer.
// Holds the FSM state encoding and the rotate direction codes.
package rotate_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/rotate_step.sv
// One-bit circular rotation of an N-bit word.
// The dir input selects left (bit i -> i+1) or right (bit i -> i-1).
module rotate_step
  import rotate_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] data,
  input  logic         dir,
  output logic [N-1:0] result
);

  always_comb begin
    if (dir == DIR_LEFT) begin
      result = {data[N-2:0], data[N-1]};
    end else begin
      result = {data[0], data[N-1:1]};
    end
  end

endmodule

// File: rtl/rotate_sequencer.sv
// Multi-cycle circular rotator: rotates one bit per clock, up_amount times,
// then holds the result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request, up_ready high
// BUSY  | rotating one bit per cycle, count holds remaining steps
// DONE  | result valid on down_data, waiting for down_ready
module rotate_sequencer
  import rotate_pkg::*;
#(
  parameter int N = 8,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [N-1:0] up_data,
  input  logic [W-1:0] up_amount,
  input  logic         up_dir,
  output logic         down_valid,
  input  logic         down_ready,
  output logic [N-1:0] down_data,
  output logic         busy
);

  state_t state, state_next;

  logic [N-1:0] data_q;
  logic [W-1:0] count_q;
  logic         dir_q;
  logic [N-1:0] rotated;
  logic         load;
  logic         step;

  rotate_step #(.N(N)) u_step (
    .data   (data_q),
    .dir    (dir_q),
    .result (rotated)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    up_ready   = 1'b0;
    down_valid = 1'b0;
    busy       = 1'b1;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        up_ready = 1'b1;
        busy     = 1'b0;
        if (up_valid) begin
          load       = 1'b1;
          state_next = (up_amount != '0) ? BUSY : DONE;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (count_q == W'(1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        down_valid = 1'b1;
        if (down_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // count only decrements in BUSY, which is entered with a nonzero amount
  // and left when it reaches 1, so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      count_q <= '0;
      dir_q   <= DIR_LEFT;
    end else if (load) begin
      data_q  <= up_data;
      count_q <= up_amount;
      dir_q   <= up_dir;
    end else if (step) begin
      data_q  <= rotated;
      count_q <= count_q - W'(1);
    end
  end

  assign down_data = data_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed bench for rotate_sequencer (N = 8): hand-computed results,
// latencies, stall behaviour and reset abort.
module tb_rotate_sequencer;

  localparam int N = 8;
  localparam int W = 3;

  logic         clk;
  logic         rst_n;
  logic         up_valid;
  logic         up_ready;
  logic [N-1:0] up_data;
  logic [W-1:0] up_amount;
  logic         up_dir;
  logic         down_valid;
  logic         down_ready;
  logic [N-1:0] down_data;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  rotate_sequencer #(.N(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .up_valid   (up_valid),
    .up_ready   (up_ready),
    .up_data    (up_data),
    .up_amount  (up_amount),
    .up_dir     (up_dir),
    .down_valid (down_valid),
    .down_ready (down_ready),
    .down_data  (down_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, scramble the inputs after acceptance, measure latency,
  // optionally stall in DONE for hold cycles, then consume.
  task automatic run_op(input string tag, input logic [N-1:0] data, input logic [W-1:0] amt,
                        input logic dir, input logic [N-1:0] exp_data, input int exp_lat,
                        input int hold);
    int   lat;
    logic ready_seen;
    logic stable_bad;
    @(negedge clk);
    check({tag, "_idle_ready"}, 32'(up_ready), 32'd1);
    check({tag, "_idle_busy"}, 32'(busy), 32'd0);
    up_valid  = 1'b1;
    up_data   = data;
    up_amount = amt;
    up_dir    = dir;
    @(posedge clk);
    #1;
    up_valid  = 1'b0;
    up_data   = ~data;
    up_amount = W'($urandom_range(0, 7));
    up_dir    = ~dir;
    lat = 1;
    ready_seen = 1'b0;
    while (!down_valid && lat < 20) begin
      if (up_ready) ready_seen = 1'b1;
      if (!busy) ready_seen = 1'b1;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_ready_low_busy_high"}, 32'(ready_seen), 32'd0);
    check({tag, "_data"}, 32'(down_data), 32'(exp_data));
    check({tag, "_done_busy"}, 32'(busy), 32'd1);
    stable_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      up_data  = N'($urandom);
      up_valid = 1'b1;
      @(posedge clk);
      #1;
      if (down_data !== exp_data || down_valid !== 1'b1 || up_ready !== 1'b0) stable_bad = 1'b1;
    end
    up_valid = 1'b0;
    if (hold > 0) check({tag, "_stall_stable"}, 32'(stable_bad), 32'd0);
    down_ready = 1'b1;
    @(posedge clk);
    #1;
    down_ready = 1'b0;
    check({tag, "_consumed_valid"}, 32'(down_valid), 32'd0);
    check({tag, "_consumed_idle"}, {30'd0, up_ready, busy}, 32'b10);
  endtask

  initial begin
    logic dv_seen;
    rst_n      = 1'b0;
    up_valid   = 1'b0;
    up_data    = '0;
    up_amount  = '0;
    up_dir     = 1'b0;
    down_ready = 1'b0;
    #12;
    check("reset_outputs", {down_data, 21'd0, up_ready, down_valid, busy}, {8'h00, 21'd0, 3'b100});
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", {down_data, 21'd0, up_ready, down_valid, busy}, {8'h00, 21'd0, 3'b100});

    run_op("left3",  8'b10110001, 3'd3, 1'b0, 8'b10001101, 4, 0);
    run_op("right3", 8'b10110001, 3'd3, 1'b1, 8'b00110110, 4, 0);
    run_op("amt0",   8'hA5,       3'd0, 1'b0, 8'hA5,       1, 0);
    run_op("right7", 8'h01,       3'd7, 1'b1, 8'h02,       8, 0);
    run_op("left1_wrap", 8'h81,   3'd1, 1'b0, 8'h03,       2, 0);
    run_op("stall",  8'h3C,       3'd2, 1'b0, 8'hF0,       3, 5);

    // reset during BUSY: amount 5, abort in the second busy cycle
    @(negedge clk);
    up_valid  = 1'b1;
    up_data   = 8'h5A;
    up_amount = 3'd5;
    up_dir    = 1'b0;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    @(posedge clk);
    #1;
    check("mid_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy_reset", {down_data, 21'd0, up_ready, down_valid, busy}, {8'h00, 21'd0, 3'b100});
    @(negedge clk);
    rst_n = 1'b1;
    dv_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (down_valid || busy) dv_seen = 1'b1;
    end
    check("no_valid_after_reset", 32'(dv_seen), 32'd0);
    run_op("after_reset", 8'hF0, 3'd4, 1'b0, 8'h0F, 5, 0);

    // reset while DONE with a result pending
    @(negedge clk);
    up_valid  = 1'b1;
    up_data   = 8'h77;
    up_amount = 3'd0;
    @(posedge clk);
    #1;
    up_valid = 1'b0;
    check("mid_done_pre", 32'(down_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_done_reset", {down_data, 21'd0, up_ready, down_valid, busy}, {8'h00, 21'd0, 3'b100});
    @(negedge clk);
    rst_n = 1'b1;
    dv_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (down_valid) dv_seen = 1'b1;
    end
    check("no_valid_after_done_reset", 32'(dv_seen), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
